// File: rtl/oka_pkg.sv
// Shared types and helpers for the overlap-free Karatsuba partial-product generator.
// Contents: FSM state enum, half-width derivation, even/odd coefficient split.
// The split works on a fixed maximum width so any even N up to OKA_N_MAX can use it.
package oka_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned OKA_N_MAX = 64;
    localparam int unsigned OKA_H_MAX = OKA_N_MAX / 2;

    // Half width of an N-bit operand; N is required to be even.
    function automatic int unsigned half_width(input int unsigned n);
        return n / 2;
    endfunction

    typedef struct packed {
        logic [OKA_H_MAX-1:0] ev;
        logic [OKA_H_MAX-1:0] od;
    } split_t;

    // ev[k] = v[2k], od[k] = v[2k+1]. Callers zero-extend narrower operands,
    // so coefficients above the real half width come out as zero.
    function automatic split_t split_eo(input logic [OKA_N_MAX-1:0] v);
        split_t s;
        s = '0;
        for (int k = 0; k < OKA_H_MAX; k++) begin
            s.ev[k] = v[2*k];
            s.od[k] = v[2*k+1];
        end
        return s;
    endfunction

endpackage

// File: rtl/oka_pp_lane.sv
// One serial shift-XOR accumulator computing a carry-less H x H product.
// Ports: load_i captures multiplicand/multiplier and clears the accumulator;
// step_i consumes one multiplier bit per cycle; acc_o is the (2H-1)-bit product.
module oka_pp_lane #(
    parameter int unsigned H = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load_i,
    input  logic           step_i,
    input  logic [H-1:0]   mcand_i,
    input  logic [H-1:0]   mplier_i,
    output logic [2*H-2:0] acc_o
);

    localparam int unsigned W = 2*H - 1;

    logic [W-1:0] mcand_q, mcand_d;
    logic [H-1:0] mplier_q, mplier_d;
    logic [W-1:0] acc_q, acc_d;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (load_i) begin
            mcand_d  = {{(H-1){1'b0}}, mcand_i};
            mplier_d = mplier_i;
            acc_d    = '0;
        end else if (step_i) begin
            // Multiplier LSB selects the current shifted multiplicand;
            // the multiplicand moves up one power of x per step.
            if (mplier_q[0]) begin
                acc_d = acc_q ^ mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/oka_even_odd_pp_seq.sv
// Sequential even/odd partial-product generator: ee, eo, oe, oo half-products of a, b.
// Ports: a/b + in_valid/in_ready accept a job; pp_* + out_valid/out_ready return it.
// Latency H cycles from acceptance to out_valid; one job in flight, results held until out_ready.
module oka_even_odd_pp_seq
    import oka_pkg::*;
#(
    parameter int unsigned N = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-2:0] pp_ee,
    output logic [N-2:0] pp_eo,
    output logic [N-2:0] pp_oe,
    output logic [N-2:0] pp_oo,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int unsigned H  = half_width(N);
    localparam int unsigned CW = (H > 1) ? $clog2(H) : 1;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           load;
    logic           step;

    // Even/odd split of both operands.
    logic [OKA_N_MAX-1:0] a_ext, b_ext;
    split_t               sa, sb;
    logic [H-1:0]         ae, ao, be, bo;
    logic                 unused_split;

    assign a_ext = {{(OKA_N_MAX-N){1'b0}}, a};
    assign b_ext = {{(OKA_N_MAX-N){1'b0}}, b};
    assign sa    = split_eo(a_ext);
    assign sb    = split_eo(b_ext);
    assign ae    = sa.ev[H-1:0];
    assign ao    = sa.od[H-1:0];
    assign be    = sb.ev[H-1:0];
    assign bo    = sb.od[H-1:0];
    // Coefficients above H are always zero; fold them away explicitly.
    assign unused_split = ^{sa, sb};

    // Control FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                step  = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(H-1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake outputs decode directly from the state register, so there is
    // no combinational path from any input to any output.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);

    // Four lanes: ee/oe share multiplier Be, eo/oo share Bo.
    oka_pp_lane #(.H(H)) u_lane_ee (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load),
        .step_i   (step),
        .mcand_i  (ae),
        .mplier_i (be),
        .acc_o    (pp_ee)
    );

    oka_pp_lane #(.H(H)) u_lane_eo (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load),
        .step_i   (step),
        .mcand_i  (ae),
        .mplier_i (bo),
        .acc_o    (pp_eo)
    );

    oka_pp_lane #(.H(H)) u_lane_oe (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load),
        .step_i   (step),
        .mcand_i  (ao),
        .mplier_i (be),
        .acc_o    (pp_oe)
    );

    oka_pp_lane #(.H(H)) u_lane_oo (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load),
        .step_i   (step),
        .mcand_i  (ao),
        .mplier_i (bo),
        .acc_o    (pp_oo)
    );

endmodule

// File: tb/tb_oka_even_odd_pp_seq.sv
// Directed bench for oka_even_odd_pp_seq at N=6: reset values, products,
// latency, backpressure hold, busy-time input changes, and mid-job reset.
module tb_oka_even_odd_pp_seq;

    localparam int N = 6;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-2:0] pp_ee, pp_eo, pp_oe, pp_oo;
    logic         out_valid;
    logic         out_ready = 1'b0;

    int checks   = 0;
    int failures = 0;

    oka_even_odd_pp_seq #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pp_ee     (pp_ee),
        .pp_eo     (pp_eo),
        .pp_oe     (pp_oe),
        .pp_oo     (pp_oo),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_pp(input string tag, input logic [4:0] e_ee, input logic [4:0] e_eo,
                            input logic [4:0] e_oe, input logic [4:0] e_oo);
        check_eq({tag, "_ee"}, 32'(pp_ee), 32'(e_ee));
        check_eq({tag, "_eo"}, 32'(pp_eo), 32'(e_eo));
        check_eq({tag, "_oe"}, 32'(pp_oe), 32'(e_oe));
        check_eq({tag, "_oo"}, 32'(pp_oo), 32'(e_oo));
    endtask

    // Presents one job and leaves time at 1 unit after the accepting edge.
    task automatic send(input string tag, input logic [N-1:0] av, input logic [N-1:0] bv);
        @(posedge clk);
        #1;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        check_eq({tag, "_in_ready_pre"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_eq({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
    endtask

    // Counts edges after acceptance until out_valid; optionally scrambles
    // the operand inputs and in_valid while the job is in flight.
    task automatic wait_valid(input string tag, input bit disturb);
        int lat;
        lat = 0;
        while (lat < 20) begin
            if (disturb) begin
                in_valid = ~in_valid;
                a        = N'($urandom);
                b        = N'($urandom);
            end
            @(posedge clk);
            lat++;
            #1;
            if (out_valid) break;
        end
        in_valid = 1'b0;
        check_eq({tag, "_latency"}, 32'(lat), 32'd3);
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq({tag, "_out_valid_after"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        // Reset state.
        #12;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_pp", 32'({pp_ee, pp_eo, pp_oe, pp_oo}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Ae=Ao=Be=Bo=001.
        send("t1", 6'b000011, 6'b000011);
        wait_valid("t1", 1'b0);
        check_pp("t1", 5'b00001, 5'b00001, 5'b00001, 5'b00001);
        consume("t1");

        // All halves 111: (1+x+x^2)^2 = 1+x^2+x^4.
        send("t2", 6'b111111, 6'b111111);
        wait_valid("t2", 1'b0);
        check_pp("t2", 5'b10101, 5'b10101, 5'b10101, 5'b10101);
        consume("t2");

        // Ae=111, Ao=000, Be=001, Bo=000.
        send("t3", 6'b010101, 6'b000001);
        wait_valid("t3", 1'b0);
        check_pp("t3", 5'b00111, 5'b00000, 5'b00000, 5'b00000);
        consume("t3");

        // Ae=010, Ao=001, Be=001, Bo=010: ee=x, eo=x^2, oe=1, oo=x.
        send("t4", 6'b000110, 6'b001001);
        wait_valid("t4", 1'b0);
        check_pp("t4", 5'b00010, 5'b00100, 5'b00001, 5'b00010);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_eq("bp_out_valid", 32'(out_valid), 32'd1);
            check_eq("bp_in_ready", 32'(in_ready), 32'd0);
            check_pp("bp_hold", 5'b00010, 5'b00100, 5'b00001, 5'b00010);
        end
        consume("t4");

        // Inputs scrambled while busy; result follows the accepted operands.
        send("t5", 6'b000011, 6'b000011);
        wait_valid("t5", 1'b1);
        check_pp("t5", 5'b00001, 5'b00001, 5'b00001, 5'b00001);
        consume("t5");

        // Reset during step 1 discards the job.
        send("t6", 6'b111111, 6'b111111);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("mid_rst_pp", 32'({pp_ee, pp_eo, pp_oe, pp_oo}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_eq("post_rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);

        send("t7", 6'b111111, 6'b111111);
        wait_valid("t7", 1'b0);
        check_pp("t7", 5'b10101, 5'b10101, 5'b10101, 5'b10101);
        consume("t7");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
